seven_segment_capture: RTL and testbench

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

---
 rtl/seven_segment_capture_pkg.sv | 25 ++
 rtl/seven_segment_capture_if.sv | 19 +
 rtl/seven_segment_capture_decode_lut.sv | 24 ++
 rtl/seven_segment_capture.sv | 130 +++++++++++++
 tb/tb_seven_segment_capture.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_segment_capture_pkg.sv
// Shared seven-segment definitions.
//   state_t      : capture FSM states (IDLE / SETTLE / HELD)
//   GLYPH        : 16 active-high 7-bit hex glyphs, bit6..bit0 = a..g,
//                  the same table the encoder LUT drives segments from
//   en_selected  : 1 when exactly one active-low digit enable is low
package seven_segment_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HELD
   } state_t;

   localparam logic [6:0] GLYPH [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79,   // 0 1 2 3
      7'h33, 7'h5B, 7'h5F, 7'h70,   // 4 5 6 7
      7'h7F, 7'h7B, 7'h77, 7'h1F,   // 8 9 A b
      7'h4E, 7'h3D, 7'h4F, 7'h47    // C d E F
   };

   function automatic logic en_selected(input logic [2:0] en);
      return (en == 3'b110) || (en == 3'b101) || (en == 3'b011);
   endfunction

endpackage

// File: rtl/seven_segment_capture_if.sv
// Observed display bus plus captured-frame outputs.
//   iSEG   : segment bus, active-low, bit7..bit0 = a,b,c,d,e,f,g,dp
//   iEN    : digit enables, active-low, iEN[0] = least-significant digit
//   oVALUE : last complete frame, digit n in [4n+3:4n]
//   oDP    : decimal point per digit, 1 = lit
//   oERR   : per digit, 1 = pattern was not a legal hex glyph
//   oVALID : one-cycle strobe marking an update of oVALUE/oDP/oERR
// master = the side driving the display (testbench), slave = the capture block.
interface seven_segment_capture_if;
   logic [7:0]  iSEG;
   logic [2:0]  iEN;
   logic [11:0] oVALUE;
   logic [2:0]  oDP;
   logic [2:0]  oERR;
   logic        oVALID;

   modport master (output iSEG, iEN, input oVALUE, oDP, oERR, oVALID);
   modport slave  (input iSEG, iEN, output oVALUE, oDP, oERR, oVALID);
endinterface

// File: rtl/seven_segment_capture_decode_lut.sv
// Combinational inverse glyph lookup.
//   pattern_i : active-high 7-bit segment pattern (a..g)
//   nibble_o  : hex value of the matching glyph, 0 when no match
//   match_o   : 1 when pattern_i is one of the 16 hex glyphs
module seven_segment_decode_lut
   import seven_segment_capture_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic [3:0] nibble_o,
   output logic       match_o
);

   always_comb begin
      nibble_o = '0;
      match_o  = 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (pattern_i == GLYPH[i]) begin
            nibble_o = i[3:0];
            match_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seven_segment_capture.sv
// Captures a 3-digit multiplexed seven-segment display into hex nibbles.
// A digit is accepted once the same {segments, enables} sample has been seen
// STABLE_CYCLES times in a row; a frame is published once all three digits
// have been captured.
//   iCLK : system clock, rising edge
//   iRST : asynchronous active-high reset
//   bus  : seven_segment_capture_if slave (iSEG/iEN in, oVALUE/oDP/oERR/oVALID out)
module seven_segment_capture
   import seven_segment_capture_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16
)
(
   input  logic                    iCLK,
   input  logic                    iRST,
   seven_segment_capture_if.slave  bus
);

   logic [7:0]  seg_q, seg_prev_q;
   logic [2:0]  en_q, en_prev_q;
   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [11:0] nib_q;
   logic [2:0]  dp_q, err_q, seen_q, seen_d;
   logic [11:0] value_q;
   logic [2:0]  odp_q, oerr_q;
   logic        valid_q;

   logic        sel, same, capture, complete;
   logic [3:0]  lut_nib;
   logic        lut_match;

   seven_segment_decode_lut u_lut (
      .pattern_i (~seg_q[7:1]),
      .nibble_o  (lut_nib),
      .match_o   (lut_match)
   );

   always_comb begin
      sel      = en_selected(en_q);
      same     = ({seg_q, en_q} == {seg_prev_q, en_prev_q});
      capture  = (state_q == ST_SETTLE) && same &&
                 (cnt_q == 8'(STABLE_CYCLES - 1));
      complete = &seen_q;
      // A capture on the completion edge belongs to the next frame, so the
      // clear is applied first and the new digit's flag is OR-ed in after.
      seen_d   = (complete ? 3'b000 : seen_q) | (capture ? ~en_q : 3'b000);
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         seg_q      <= '1;
         en_q       <= '1;
         seg_prev_q <= '1;
         en_prev_q  <= '1;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         nib_q      <= '0;
         dp_q       <= '0;
         err_q      <= '0;
         seen_q     <= '0;
         value_q    <= '0;
         odp_q      <= '0;
         oerr_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         seg_q      <= bus.iSEG;
         en_q       <= bus.iEN;
         seg_prev_q <= seg_q;
         en_prev_q  <= en_q;

         case (state_q)
            ST_IDLE: begin
               if (sel) begin
                  state_q <= ST_SETTLE;
                  cnt_q   <= 8'd1;
               end
            end
            ST_SETTLE: begin
               if (same) begin
                  cnt_q <= cnt_q + 8'd1;
                  if (capture) state_q <= ST_HELD;
               end else if (sel) begin
                  cnt_q <= 8'd1;
               end else begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end
            end
            ST_HELD: begin
               if (!same) begin
                  if (sel) begin
                     state_q <= ST_SETTLE;
                     cnt_q   <= 8'd1;
                  end else begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase

         valid_q <= complete;
         if (complete) begin
            value_q <= nib_q;
            odp_q   <= dp_q;
            oerr_q  <= err_q;
         end

         seen_q <= seen_d;
         for (int unsigned d = 0; d < 3; d++) begin
            if (capture && !en_q[d]) begin
               nib_q[4*d +: 4] <= lut_match ? lut_nib : 4'h0;
               dp_q[d]         <= ~seg_q[0];
               err_q[d]        <= ~lut_match;
            end
         end
      end
   end

   assign bus.oVALUE = value_q;
   assign bus.oDP    = odp_q;
   assign bus.oERR   = oerr_q;
   assign bus.oVALID = valid_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
module tb_seven_segment_capture;

   localparam int unsigned STABLE = 4;
   localparam logic [6:0] G [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   logic clk = 1'b0;
   logic rst = 1'b1;

   seven_segment_capture_if bus ();

   seven_segment_capture #(.STABLE_CYCLES(STABLE)) dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   logic [11:0] last_val;
   logic [2:0]  last_dp, last_err;

   // Reference model: a digit is taken when a selected sample has repeated
   // exactly STABLE times; the frame appears one edge after the third digit.
   logic [10:0] pending, last;
   int          run;
   bit          frame_pending;
   logic [3:0]  m_nib [3];
   logic        m_dp [3], m_err [3], m_seen [3];
   logic        exp_valid;
   logic [11:0] exp_value;
   logic [2:0]  exp_dp, exp_err;

   function automatic logic [7:0] enc(input logic [3:0] n, input logic dp);
      return ~{G[n], dp};
   endfunction

   function automatic logic [4:0] decode(input logic [7:0] seg);
      logic [6:0] p;
      p = ~seg[7:1];
      for (int i = 0; i < 16; i++)
         if (G[i] == p) return {1'b1, 4'(i)};
      return 5'b0;
   endfunction

   task model_reset();
      pending       = {8'hFF, 3'b111};
      last          = {8'hFF, 3'b111};
      run           = 0;
      frame_pending = 0;
      for (int d = 0; d < 3; d++) begin
         m_nib[d] = 4'h0; m_dp[d] = 1'b0; m_err[d] = 1'b0; m_seen[d] = 1'b0;
      end
      exp_valid = 1'b0; exp_value = '0; exp_dp = '0; exp_err = '0;
   endtask

   task model_edge();
      logic [7:0] s;
      logic [2:0] e;
      logic [4:0] dec;
      int d;
      exp_valid = 1'b0;
      if (frame_pending) begin
         exp_valid = 1'b1;
         for (int k = 0; k < 3; k++) begin
            exp_value[4*k +: 4] = m_nib[k];
            exp_dp[k]  = m_dp[k];
            exp_err[k] = m_err[k];
            m_seen[k]  = 1'b0;
         end
         frame_pending = 0;
      end
      if (pending == last) run++; else run = 1;
      last = pending;
      s = pending[10:3];
      e = pending[2:0];
      if ($countones(~e) == 1 && run == STABLE) begin
         d = (e == 3'b110) ? 0 : (e == 3'b101) ? 1 : 2;
         dec = decode(s);
         m_nib[d]  = dec[3:0];
         m_err[d]  = ~dec[4];
         m_dp[d]   = ~s[0];
         m_seen[d] = 1'b1;
         if (m_seen[0] && m_seen[1] && m_seen[2]) frame_pending = 1;
      end
   endtask

   task check_cycle();
      n_tests++;
      assert ({bus.oVALID, bus.oVALUE, bus.oDP, bus.oERR} ===
              {exp_valid, exp_value, exp_dp, exp_err})
      else begin
         n_fail++;
         $error("FAIL cycle: got v=%b val=%h dp=%b err=%b want v=%b val=%h dp=%b err=%b",
                bus.oVALID, bus.oVALUE, bus.oDP, bus.oERR,
                exp_valid, exp_value, exp_dp, exp_err);
      end
      if (bus.oVALID === 1'b1) begin
         pulses++;
         last_val = bus.oVALUE; last_dp = bus.oDP; last_err = bus.oERR;
      end
   endtask

   task step(input logic [7:0] seg, input logic [2:0] en);
      @(negedge clk);
      bus.iSEG = seg;
      bus.iEN  = en;
      @(posedge clk);
      model_edge();
      pending = {seg, en};
      #1 check_cycle();
   endtask

   task hold(input logic [7:0] seg, input logic [2:0] en, input int n);
      for (int i = 0; i < n; i++) step(seg, en);
   endtask

   task do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.iSEG = 8'hFF;
      bus.iEN  = 3'b111;
      #1;
      n_tests++;
      assert ({bus.oVALID, bus.oVALUE, bus.oDP, bus.oERR} === 19'b0)
      else begin
         n_fail++;
         $error("FAIL reset_async: got %h want 0", {bus.oVALID, bus.oVALUE, bus.oDP, bus.oERR});
      end
      @(posedge clk);
      #1;
      n_tests++;
      assert ({bus.oVALID, bus.oVALUE, bus.oDP, bus.oERR} === 19'b0)
      else begin
         n_fail++;
         $error("FAIL reset_held: got %h want 0", {bus.oVALID, bus.oVALUE, bus.oDP, bus.oERR});
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic expect_frames(input string tag, input int np, input logic [11:0] v,
                                input logic [2:0] dp, input logic [2:0] er);
      n_tests++;
      assert (pulses === np)
      else begin
         n_fail++;
         $error("FAIL %s pulses: got %0d want %0d", tag, pulses, np);
      end
      if (np > 0) begin
         n_tests++;
         assert ({last_val, last_dp, last_err} === {v, dp, er})
         else begin
            n_fail++;
            $error("FAIL %s frame: got val=%h dp=%b err=%b want val=%h dp=%b err=%b",
                   tag, last_val, last_dp, last_err, v, dp, er);
         end
      end
      pulses = 0;
   endtask

   initial begin
      bus.iSEG = 8'hFF;
      bus.iEN  = 3'b111;
      model_reset();
      do_reset();

      // "0","1","A" on digits 0..2
      hold(8'h03, 3'b110, 6);
      hold(8'h9F, 3'b101, 6);
      hold(8'h11, 3'b011, 6);
      hold(8'hFF, 3'b111, 3);
      expect_frames("basic", 1, 12'hA10, 3'b000, 3'b000);

      // digit 1 held too briefly, then properly
      hold(8'h03, 3'b110, 6);
      hold(8'h9F, 3'b101, 3);
      hold(8'h11, 3'b011, 6);
      expect_frames("short_hold", 0, '0, '0, '0);
      hold(8'h9F, 3'b101, 4);
      hold(8'hFF, 3'b111, 2);
      expect_frames("short_then_ok", 1, 12'hA10, 3'b000, 3'b000);

      // blank pattern with dp on digit 2
      hold(8'h03, 3'b110, 6);
      hold(8'h9F, 3'b101, 6);
      hold(8'hFE, 3'b011, 6);
      hold(8'hFF, 3'b111, 2);
      expect_frames("bad_glyph", 1, 12'h010, 3'b100, 3'b100);

      // two enables low is never a capture
      hold(8'h03, 3'b100, 10);
      hold(8'h9F, 3'b101, 6);
      hold(8'h11, 3'b011, 6);
      expect_frames("multi_en", 0, '0, '0, '0);
      hold(8'h03, 3'b110, 6);
      hold(8'hFF, 3'b111, 2);
      expect_frames("multi_en_done", 1, 12'hA10, 3'b000, 3'b000);

      // reset mid-frame discards partial captures
      hold(enc(4'h4, 1'b1), 3'b110, 6);
      hold(enc(4'h4, 1'b1), 3'b101, 6);
      do_reset();
      hold(8'h11, 3'b011, 6);
      hold(8'h9F, 3'b101, 6);
      hold(8'hFF, 3'b111, 2);
      expect_frames("reset_partial", 0, '0, '0, '0);
      hold(8'h03, 3'b110, 6);
      hold(8'hFF, 3'b111, 2);
      expect_frames("reset_fresh", 1, 12'hA10, 3'b000, 3'b000);

      // continuous multiplex of 3F5
      for (int f = 0; f < 3; f++) begin
         hold(enc(4'h5, 1'b0), 3'b110, 5);
         hold(enc(4'hF, 1'b0), 3'b101, 5);
         hold(enc(4'h3, 1'b0), 3'b011, 5);
      end
      hold(8'hFF, 3'b111, 2);
      expect_frames("mux_3F5", 3, 12'h3F5, 3'b000, 3'b000);

      // randomized patterns against the model
      for (int i = 0; i < 80; i++) begin
         logic [2:0] en;
         logic [7:0] seg;
         case ($urandom_range(0, 5))
            0, 4:    en = 3'b110;
            1:       en = 3'b101;
            2, 5:    en = 3'b011;
            default: en = 3'($urandom);
         endcase
         if ($urandom_range(0, 3) != 0)
            seg = enc(4'($urandom), 1'($urandom));
         else
            seg = 8'($urandom);
         hold(seg, en, $urandom_range(1, 7));
      end
      hold(8'hFF, 3'b111, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
